// File: rtl/sub_bits_serial.sv
`default_nettype none
// ============================================================================
// Module      : sub_bits_serial
// Description : Multi-cycle subtractor RC = RA - RB for the area-reduced ALU
//               path. Computes RA + ~RB + 1 through a BITS_PER_CYCLE-wide
//               ripple slice, LSB slice first, one slice per clock.
//
// Ports       : clock    - rising-edge clock
//               clear    - synchronous active-low reset
//               start    - request; RA/RB are sampled when accepted
//               RA, RB   - minuend, subtrahend (WIDTH bits)
//               RC       - registered difference
//               borrow   - unsigned borrow out (RA < RB)
//               overflow - signed two's-complement overflow
//               busy     - high while the operation is in progress
//               done     - one-cycle pulse, RC/borrow/overflow valid
//
// Revision    : 1.0 - initial release
// ============================================================================
module sub_bits_serial #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] RA,
    input  logic [WIDTH-1:0] RB,
    output logic [WIDTH-1:0] RC,
    output logic             borrow,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    // Number of slices per operation and the counter that walks them.
    localparam int c_n     = WIDTH / BITS_PER_CYCLE;
    localparam int c_cnt_w = (c_n > 1) ? $clog2(c_n) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_n - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                      r_state;
    logic [WIDTH-1:0]            r_op_a;
    logic [WIDTH-1:0]            r_op_b;      // holds ~RB
    logic [WIDTH-1:0]            r_acc;       // result shift register
    logic                        r_carry;
    logic [c_cnt_w-1:0]          r_count;
    logic                        r_sign_a;    // RA[WIDTH-1] at acceptance
    logic                        r_sign_b;    // RB[WIDTH-1] at acceptance

    logic [BITS_PER_CYCLE:0]     w_sum;
    logic [WIDTH-1:0]            w_acc_next;
    logic                        w_carry_out;

    // One ripple slice: low bits of both operands plus the running carry.
    assign w_sum = {1'b0, r_op_a[BITS_PER_CYCLE-1:0]}
                 + {1'b0, r_op_b[BITS_PER_CYCLE-1:0]}
                 + {{BITS_PER_CYCLE{1'b0}}, r_carry};
    assign w_carry_out = w_sum[BITS_PER_CYCLE];

    // New slice enters at the top so that after c_n shifts the first (LSB)
    // slice has reached bit 0.
    generate
        if (BITS_PER_CYCLE == WIDTH) begin : g_single_slice
            assign w_acc_next = w_sum[BITS_PER_CYCLE-1:0];
        end else begin : g_multi_slice
            assign w_acc_next = {w_sum[BITS_PER_CYCLE-1:0],
                                 r_acc[WIDTH-1:BITS_PER_CYCLE]};
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!clear) begin
            r_state  <= ST_IDLE;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_acc    <= '0;
            r_carry  <= 1'b0;
            r_count  <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            RC       <= '0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (r_state)
                // DONE behaves like IDLE for acceptance, which gives
                // back-to-back issue without an extra idle cycle.
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_op_a   <= RA;
                        r_op_b   <= ~RB;
                        r_acc    <= '0;
                        r_carry  <= 1'b1;
                        r_count  <= '0;
                        r_sign_a <= RA[WIDTH-1];
                        r_sign_b <= RB[WIDTH-1];
                        busy     <= 1'b1;
                        r_state  <= ST_RUN;
                    end else begin
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                ST_RUN: begin
                    r_op_a  <= r_op_a >> BITS_PER_CYCLE;
                    r_op_b  <= r_op_b >> BITS_PER_CYCLE;
                    r_acc   <= w_acc_next;
                    r_carry <= w_carry_out;
                    if (r_count == c_last) begin
                        // Outputs update only here, so they never expose
                        // a partially assembled result.
                        RC       <= w_acc_next;
                        borrow   <= ~w_carry_out;
                        overflow <= (r_sign_a != r_sign_b) &&
                                    (w_acc_next[WIDTH-1] != r_sign_a);
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        r_count  <= '0;
                        r_state  <= ST_DONE;
                    end else begin
                        r_count <= r_count + c_cnt_w'(1);
                    end
                end

                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sub_bits_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_sub_bits_serial
// Description : Self-checking bench for sub_bits_serial. Table of directed
//               subtraction vectors plus hand-written abort, back-to-back
//               and 8-bits-per-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sub_bits_serial;

    logic        clock;
    logic        clear;
    logic        start;
    logic [31:0] RA;
    logic [31:0] RB;
    logic [31:0] RC;
    logic        borrow;
    logic        overflow;
    logic        busy;
    logic        done;

    logic        start8;
    logic [31:0] ra8;
    logic [31:0] rb8;
    logic [31:0] rc8;
    logic        borrow8;
    logic        overflow8;
    logic        busy8;
    logic        done8;

    int checks   = 0;
    int failures = 0;

    sub_bits_serial #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
        .clock    (clock),
        .clear    (clear),
        .start    (start),
        .RA       (RA),
        .RB       (RB),
        .RC       (RC),
        .borrow   (borrow),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    sub_bits_serial #(.WIDTH(32), .BITS_PER_CYCLE(8)) dut8 (
        .clock    (clock),
        .clear    (clear),
        .start    (start8),
        .RA       (ra8),
        .RB       (rb8),
        .RC       (rc8),
        .borrow   (borrow8),
        .overflow (overflow8),
        .busy     (busy8),
        .done     (done8)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] rc;
        logic        brw;
        logic        ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Present operands with start for one edge; afterwards scramble RA/RB
    // so that any use of unlatched operands shows up in the result.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        RA    = a;
        RB    = b;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        RA    = $urandom;
        RB    = $urandom;
    endtask

    // Called just after the accepting edge; returns edges until done and
    // the number of cycles busy was seen high on the way.
    task automatic wait_done(output int lat, output int busy_cnt,
                             output int both_hi);
        lat      = 0;
        busy_cnt = 0;
        both_hi  = 0;
        while (!done && lat < 200) begin
            if (busy) busy_cnt++;
            @(posedge clock);
            #1;
            lat++;
        end
        if (busy && done) both_hi = 1;
    endtask

    vec_t vecs[8];
    int   lat;
    int   bcnt;
    int   both;
    int   saw_done;

    initial begin
        vecs[0] = '{32'd10,        32'd3,        32'h0000_0007, 1'b0, 1'b0};
        vecs[1] = '{32'd3,         32'd10,       32'hFFFF_FFF9, 1'b1, 1'b0};
        vecs[2] = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1};
        vecs[3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1};
        vecs[4] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[5] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0};
        vecs[6] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[7] = '{32'h1234_5678, 32'h0000_FFFF, 32'h1233_5679, 1'b0, 1'b0};

        clear  = 1'b0;
        start  = 1'b1;           // must be ignored while clear is low
        RA     = 32'd10;
        RB     = 32'd3;
        start8 = 1'b0;
        ra8    = '0;
        rb8    = '0;

        // Reset: two edges with clear low.
        repeat (2) @(posedge clock);
        #1;
        chk("reset_rc",       RC,              32'h0);
        chk("reset_borrow",   {31'b0, borrow},   32'h0);
        chk("reset_overflow", {31'b0, overflow}, 32'h0);
        chk("reset_busy",     {31'b0, busy},     32'h0);
        chk("reset_done",     {31'b0, done},     32'h0);
        start = 1'b0;
        clear = 1'b1;
        @(posedge clock);
        #1;
        chk("idle_busy", {31'b0, busy}, 32'h0);

        // Table-driven vectors, each run to completion from IDLE.
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].ra, vecs[i].rb);
            wait_done(lat, bcnt, both);
            chk($sformatf("v%0d_latency", i),   lat,  32'd32);
            chk($sformatf("v%0d_busy_cyc", i),  bcnt, 32'd32);
            chk($sformatf("v%0d_busy_done", i), both, 32'd0);
            chk($sformatf("v%0d_rc", i),        RC,   vecs[i].rc);
            chk($sformatf("v%0d_borrow", i),   {31'b0, borrow},   {31'b0, vecs[i].brw});
            chk($sformatf("v%0d_overflow", i), {31'b0, overflow}, {31'b0, vecs[i].ovf});
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_done_pulse", i), {31'b0, done}, 32'h0);
            chk($sformatf("v%0d_rc_hold", i),    RC,           vecs[i].rc);
        end

        // Abort: start 100-1, poke operands/start mid-run, then clear.
        saw_done = 0;
        issue(32'd100, 32'd1);
        repeat (5) begin
            @(posedge clock);
            #1;
            if (done) saw_done = 1;
        end
        RA    = 32'hDEAD_BEEF;
        RB    = 32'h0000_1234;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        chk("abort_busy_mid", {31'b0, busy}, 32'h1);
        chk("abort_rc_hold",  RC,            32'h1233_5679);
        repeat (3) begin
            @(posedge clock);
            #1;
            if (done) saw_done = 1;
        end
        clear = 1'b0;
        @(posedge clock);
        #1;
        clear = 1'b1;
        chk("abort_busy",     {31'b0, busy},     32'h0);
        chk("abort_rc_zero",  RC,                32'h0);
        chk("abort_done",     {31'b0, done},     32'h0);
        chk("abort_borrow",   {31'b0, borrow},   32'h0);
        repeat (40) begin
            @(posedge clock);
            #1;
            if (done || busy) saw_done = 1;
        end
        chk("abort_no_done", saw_done, 32'd0);

        // Rerun to completion, then issue back-to-back from DONE.
        issue(32'd100, 32'd1);
        wait_done(lat, bcnt, both);
        chk("rerun_latency", lat, 32'd32);
        chk("rerun_rc",      RC,  32'h0000_0063);
        chk("rerun_borrow",  {31'b0, borrow}, 32'h0);
        issue(32'd5, 32'd5);
        chk("b2b_accept_busy", {31'b0, busy}, 32'h1);
        chk("b2b_accept_done", {31'b0, done}, 32'h0);
        chk("b2b_rc_hold",     RC,            32'h0000_0063);
        wait_done(lat, bcnt, both);
        chk("b2b_latency",  lat, 32'd32);
        chk("b2b_busy_cyc", bcnt, 32'd32);
        chk("b2b_rc",       RC,  32'h0);
        chk("b2b_borrow",   {31'b0, borrow},   32'h0);
        chk("b2b_overflow", {31'b0, overflow}, 32'h0);
        @(posedge clock);
        #1;

        // Eight bits per cycle: four slices.
        ra8    = 32'h0001_0000;
        rb8    = 32'h0000_0001;
        start8 = 1'b1;
        @(posedge clock);
        #1;
        start8 = 1'b0;
        ra8    = 32'hFFFF_FFFF;
        rb8    = 32'h0;
        lat    = 0;
        while (!done8 && lat < 50) begin
            @(posedge clock);
            #1;
            lat++;
        end
        chk("bpc8_latency",  lat,  32'd4);
        chk("bpc8_rc",       rc8,  32'h0000_FFFF);
        chk("bpc8_borrow",   {31'b0, borrow8},   32'h0);
        chk("bpc8_overflow", {31'b0, overflow8}, 32'h0);
        chk("bpc8_busy",     {31'b0, busy8},     32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
